// File: rtl/fifo_ptr_ctrl_pkg.sv
// fifo_ptr_pkg: shared defaults for the FIFO pointer controller.
//   ADDR_WIDTH_DEF      default storage address width (depth = 2**ADDR_WIDTH)
//   AFULL_THRESH_DEF    default occupancy at/above which almost_full asserts
//   AEMPTY_THRESH_DEF   default occupancy at/below which almost_empty asserts
//   ptr_w()             pointer width: address bits plus one wrap bit
package fifo_ptr_pkg;

  localparam int ADDR_WIDTH_DEF    = 10;
  localparam int AFULL_THRESH_DEF  = 1020;
  localparam int AEMPTY_THRESH_DEF = 4;

  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_ptr_counter.sv
// ptr_counter: WIDTH-bit wrapping pointer register.
//   gclk    clock, rising edge
//   grst_n  asynchronous active-low reset, clears pointer
//   clr     synchronous clear (wins over en)
//   en      advance pointer by one, natural modulo-2**WIDTH wrap
//   ptr     registered pointer value
module ptr_counter #(
  parameter int WIDTH = 11
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)     ptr_d = '0;
    else if (en) ptr_d = ptr_q + WIDTH'(1);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointer and status controller for an external
// 2**ADDR_WIDTH-entry FIFO storage array (no storage held here).
//   CLK, ASYNCRESETN   clock / async active-low reset
//   clr                synchronous flush: pointers and sticky errors to 0
//   wr_req, rd_req     producer / consumer requests
//   wr_en, rd_en       accepted requests (combinational, zero latency)
//   wr_addr, rd_addr   storage addresses (pointer low bits)
//   count              occupancy 0..2**ADDR_WIDTH
//   full, empty, almost_full, almost_empty   status decoded from pointers
//   overflow, underflow                      sticky error flags
module fifo_ptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int AFULL_THRESH  = AFULL_THRESH_DEF,
  parameter int AEMPTY_THRESH = AEMPTY_THRESH_DEF
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  input  logic                  clr,
  input  logic                  wr_req,
  input  logic                  rd_req,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int            PW       = ptr_w(ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL_T  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_T = PW'(AEMPTY_THRESH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          ovf_d, ovf_q, udf_d, udf_q;

  // Acceptance is also gated by reset so nothing is accepted while it is held.
  assign wr_en = wr_req && !full  && !clr && ASYNCRESETN;
  assign rd_en = rd_req && !empty && !clr && ASYNCRESETN;

  ptr_counter #(.WIDTH(PW)) u_wr_ptr (
    .gclk   (CLK),
    .grst_n (ASYNCRESETN),
    .clr    (clr),
    .en     (wr_en),
    .ptr    (wr_ptr)
  );

  ptr_counter #(.WIDTH(PW)) u_rd_ptr (
    .gclk   (CLK),
    .grst_n (ASYNCRESETN),
    .clr    (clr),
    .en     (rd_en),
    .ptr    (rd_ptr)
  );

  assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  // Same address with differing wrap bits means the writer is one lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // Modulo subtraction stays correct across pointer wrap.
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AFULL_T);
  assign almost_empty = (count <= AEMPTY_T);

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr_req && full)  ovf_d = 1'b1;
      if (rd_req && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
module tb_fifo_ptr_ctrl;

  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          ASYNCRESETN = 1'b1;
  logic          clr = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [AW:0] wp, rp;

  fifo_ptr_ctrl #(
    .ADDR_WIDTH    (AW),
    .AFULL_THRESH  (14),
    .AEMPTY_THRESH (2)
  ) dut (
    .CLK          (CLK),
    .ASYNCRESETN  (ASYNCRESETN),
    .clr          (clr),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive requests mid-cycle, then settle before sampling.
  task automatic cyc(input logic w, input logic r, input logic c);
    @(negedge CLK);
    wr_req = w; rd_req = r; clr = c;
    #1;
  endtask

  initial begin
    // Async reset asserted away from any edge.
    #2 ASYNCRESETN = 1'b0;
    wr_req = 1'b1;
    #1;
    chk("rst_empty",  32'(empty), 1);
    chk("rst_full",   32'(full), 0);
    chk("rst_count",  32'(count), 0);
    chk("rst_waddr",  32'(wr_addr), 0);
    chk("rst_raddr",  32'(rd_addr), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull",  32'(almost_full), 0);
    chk("rst_ovf",    32'(overflow), 0);
    chk("rst_udf",    32'(underflow), 0);
    chk("rst_wr_en",  32'(wr_en), 0);
    @(negedge CLK);
    wr_req = 1'b0;
    ASYNCRESETN = 1'b1;

    // Fill: 16 writes, addresses 0..15, almost_full from count 14.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("fill_wr_en",  32'(wr_en), 1);
      chk("fill_waddr",  32'(wr_addr), i);
      chk("fill_count",  32'(count), i);
      chk("fill_afull",  32'(almost_full), (i >= 14) ? 1 : 0);
      chk("fill_aempty", 32'(almost_empty), (i <= 2) ? 1 : 0);
    end
    cyc(1'b1, 1'b0, 1'b0);
    chk("full_count", 32'(count), 16);
    chk("full_flag",  32'(full), 1);
    chk("full_wr_en", 32'(wr_en), 0);
    chk("pre_ovf",    32'(overflow), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ovf_set",    32'(overflow), 1);
    chk("ovf_count",  32'(count), 16);

    // Drain: 16 reads, addresses 0..15.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("drain_rd_en", 32'(rd_en), 1);
      chk("drain_raddr", 32'(rd_addr), i);
      chk("drain_count", 32'(count), 16 - i);
    end
    cyc(1'b0, 1'b1, 1'b0);
    chk("empty_flag",  32'(empty), 1);
    chk("empty_rd_en", 32'(rd_en), 0);
    chk("pre_udf",     32'(underflow), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("udf_set",     32'(underflow), 1);

    // Both requests at empty: write wins.
    cyc(1'b1, 1'b1, 1'b0);
    chk("be_wr_en", 32'(wr_en), 1);
    chk("be_rd_en", 32'(rd_en), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("be_count", 32'(count), 1);
    chk("be_empty", 32'(empty), 0);

    // Bring occupancy to 5: pointers then wr=21, rd=16.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("c5_count", 32'(count), 5);

    // 40 cycles of simultaneous traffic, pointers wrap past 31.
    wp = 5'd21;
    rp = 5'd16;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      chk("ss_count", 32'(count), 5);
      chk("ss_wr_en", 32'(wr_en), 1);
      chk("ss_rd_en", 32'(rd_en), 1);
      chk("ss_wptr",  32'(dut.wr_ptr), 32'(wp));
      chk("ss_rptr",  32'(dut.rd_ptr), 32'(rp));
      wp = wp + 5'd1;
      rp = rp + 5'd1;
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("ss_end_wptr", 32'(dut.wr_ptr), 29);
    chk("ss_end_rptr", 32'(dut.rd_ptr), 24);
    chk("ss_end_cnt",  32'(count), 5);

    // Refill to full (11 more writes), then both requests: read wins.
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("bf_full",  32'(full), 1);
    chk("bf_rd_en", 32'(rd_en), 1);
    chk("bf_wr_en", 32'(wr_en), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("bf_count", 32'(count), 15);
    chk("bf_nfull", 32'(full), 0);

    // Down to 9 with overflow still sticky, then flush with a write pending.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("c9_count", 32'(count), 9);
    chk("c9_ovf",   32'(overflow), 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("clr_wr_en", 32'(wr_en), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clr_count", 32'(count), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_ovf",   32'(overflow), 0);
    chk("clr_udf",   32'(underflow), 0);

    // Mid-stream async reset at count 7, checked before the next edge.
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("c7_count", 32'(count), 7);
    #1 ASYNCRESETN = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_waddr", 32'(wr_addr), 0);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_ctrl.md
FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 10, giving the address width; depth is 2^ADDR_WIDTH entries.
REQ-002 The module SHALL have parameter AFULL_THRESH, default 1020, giving the occupancy at or above which almost_full is asserted.
REQ-003 The module SHALL have parameter AEMPTY_THRESH, default 4, giving the occupancy at or below which almost_empty is asserted.
REQ-004 Port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port ASYNCRESETN  input  1  asynchronous active-low reset.
REQ-006 Port clr  input  1  synchronous flush request.
REQ-007 Port wr_req  input  1  producer write request.
REQ-008 Port rd_req  input  1  consumer read request.
REQ-009 Port wr_en  output  1  write accepted this cycle; drives the storage write strobe.
REQ-010 Port rd_en  output  1  read accepted this cycle; drives the read-pointer advance.
REQ-011 Port wr_addr  output  ADDR_WIDTH  storage write address.
REQ-012 Port rd_addr  output  ADDR_WIDTH  storage read address.
REQ-013 Port count  output  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
REQ-014 Port status outputs, each output 1: full, empty, almost_full, almost_empty, overflow, underflow.

Function
REQ-015 Write and read pointers SHALL each be ADDR_WIDTH+1 bit registers; the low ADDR_WIDTH bits drive wr_addr/rd_addr and the MSB is a wrap bit.
REQ-016 Each pointer SHALL increment by 1 modulo 2^(ADDR_WIDTH+1) in every cycle its enable is high; natural wrap applies with no saturation.
REQ-017 empty SHALL equal (wr_ptr == rd_ptr); full SHALL equal (address bits equal AND wrap bits differ); both are decoded from registered pointers only.
REQ-018 count SHALL equal wr_ptr - rd_ptr modulo 2^(ADDR_WIDTH+1), combinational from the registered pointers.
REQ-019 almost_full SHALL equal (count >= AFULL_THRESH); almost_empty SHALL equal (count <= AEMPTY_THRESH).
REQ-020 wr_en SHALL equal wr_req AND NOT full AND NOT clr; rd_en SHALL equal rd_req AND NOT empty AND NOT clr; both are combinational with zero latency.
REQ-021 Flags and count SHALL reflect an accepted request in the cycle after acceptance (1-cycle latency).
REQ-022 When full with simultaneous wr_req and rd_req: the read SHALL be accepted and the write rejected; the result is count-1 and full deasserts.
REQ-023 When empty with simultaneous wr_req and rd_req: the write SHALL be accepted and the read rejected; the result is count 1 and empty deasserts.
REQ-024 When both requests are accepted, count SHALL be unchanged and both pointers SHALL advance.
REQ-025 overflow SHALL set on the edge after any cycle with wr_req AND full, and SHALL remain set until clr or reset.
REQ-026 underflow SHALL set on the edge after any cycle with rd_req AND empty, and SHALL remain set until clr or reset.
REQ-027 clr SHALL override same-cycle requests: both pointers and both sticky flags go to 0 on the next edge.

Reset
REQ-028 ASYNCRESETN low SHALL immediately force wr_ptr=0, rd_ptr=0, overflow=0 and underflow=0, independent of CLK.
REQ-029 During reset, outputs SHALL be: empty=1, full=0, count=0, wr_addr=0, rd_addr=0, almost_empty=1, almost_full=0.
REQ-030 Reset asserted mid-stream SHALL discard all occupancy; no request is accepted while ASYNCRESETN is low (wr_en=rd_en=0).
REQ-031 Release of ASYNCRESETN SHALL be treated as synchronised externally; the first accepted request is on the first rising edge after release.

Structure
REQ-032 Shared package fifo_ptr_pkg SHALL hold the ADDR_WIDTH default, the pointer-width function (ADDR_WIDTH+1) and the threshold defaults.
REQ-033 Sub-module ptr_counter (ADDR_WIDTH+1 bit register with enable, sync clear and async active-low reset) SHALL be instantiated twice, once for write and once for read.
REQ-034 Flag, count and sticky-error logic SHALL reside in fifo_ptr_ctrl; the block contains no storage array.

Verification (bench parameters ADDR_WIDTH=4, AFULL_THRESH=14, AEMPTY_THRESH=2)
REQ-035 Reset, then 16 consecutive wr_req -> wr_addr 0..15; full=1 and count=16 after the 16th; almost_full from count 14; a 17th wr_req gives wr_en=0 and overflow=1 next cycle.
REQ-036 From full, 16 consecutive rd_req -> rd_addr 0..15; empty=1 after the last; an extra rd_req gives rd_en=0 and underflow=1.
REQ-037 Run 40 cycles of simultaneous wr_req and rd_req at count 5 -> count stays 5; both pointers wrap past 31 to 0; wrap bits toggle correctly.
REQ-038 Simultaneous wr_req and rd_req at full -> rd_en=1, wr_en=0, count 15 next cycle; the same at empty -> wr_en=1, rd_en=0, count 1.
REQ-039 Assert clr with wr_req=1 at count 9 and overflow=1 -> wr_en=0; next cycle count=0, empty=1 and overflow=0.
REQ-040 Drop ASYNCRESETN between clock edges at count 7 -> count=0 and empty=1 immediately, before the next CLK edge.
